// File: rtl/osc_reset_sequencer_if.sv
// Signal bundle between the oscillator reset sequencer and its environment.
// The sequencer uses the master modport; the surrounding fabric/bench uses slave.
interface osc_reset_sequencer_if #(
  parameter int NUM_DOMAINS = 3
);
  logic                   PLL_LOCK;
  logic                   TICK_1MHZ;
  logic                   FORCE_RESEQ;
  logic [NUM_DOMAINS-1:0] DOMAIN_RST;
  logic                   READY;
  logic                   OSC_FAULT;
  logic [2:0]             STATE;
  logic [7:0]             LAST_COUNT;

  modport master (
    input  PLL_LOCK, TICK_1MHZ, FORCE_RESEQ,
    output DOMAIN_RST, READY, OSC_FAULT, STATE, LAST_COUNT
  );

  modport slave (
    output PLL_LOCK, TICK_1MHZ, FORCE_RESEQ,
    input  DOMAIN_RST, READY, OSC_FAULT, STATE, LAST_COUNT
  );
endinterface

// File: rtl/osc_reset_sequencer.sv
// Start-up reset sequencer for RC-oscillator/CCC clock domains: settle, filter lock,
// staggered domain release, then supervise oscillator frequency per window.
module osc_reset_sequencer #(
  parameter int NUM_DOMAINS    = 3,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int LOCK_FILTER    = 8,
  parameter int STAGGER_CYCLES = 16,
  parameter int WINDOW_CYCLES  = 1000,
  parameter int TICK_MIN       = 18,
  parameter int TICK_MAX       = 22,
  parameter int FAIL_LIMIT     = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  osc_reset_sequencer_if.master io
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int LW = $clog2(LOCK_FILTER + 1);
  localparam int GW = $clog2(STAGGER_CYCLES + 1);
  localparam int WW = $clog2(WINDOW_CYCLES + 1);
  localparam int BW = $clog2(FAIL_LIMIT + 1);

  typedef enum logic [2:0] {
    S_SETTLE    = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic                   lock_s1, lock_s2, tick_s1, tick_s2, tick_s3;
  logic [SW-1:0]          settle_cnt;
  logic [LW-1:0]          lock_cnt;
  logic [GW-1:0]          stag_cnt;
  logic [3:0]             rel_idx;
  logic [WW-1:0]          win_cnt;
  logic [7:0]             tick_cnt, win_count;
  logic [BW-1:0]          bad_cnt, bad_d;
  logic                   tick_edge, settle_done, lock_ok, stag_done, last_rel;
  logic                   win_end, win_good, bad_fail, restart;
  logic [NUM_DOMAINS-1:0] dom_rst, dom_rst_d;
  logic                   ready, ready_d, osc_fault, osc_fault_d;
  logic [7:0]             last_count, last_count_d;

  assign tick_edge   = tick_s2 & ~tick_s3;
  assign settle_done = settle_cnt == SW'(SETTLE_CYCLES - 1);
  assign lock_ok     = lock_cnt == LW'(LOCK_FILTER);
  assign stag_done   = stag_cnt == GW'(STAGGER_CYCLES - 1);
  assign last_rel    = rel_idx == 4'(NUM_DOMAINS - 1);
  assign win_end     = win_cnt == WW'(WINDOW_CYCLES - 1);
  // Tick on the window's final cycle is folded into that window's count.
  assign win_count   = (tick_edge && tick_cnt != 8'hFF) ? tick_cnt + 8'd1 : tick_cnt;
  assign win_good    = (win_count >= 8'(TICK_MIN)) && (win_count <= 8'(TICK_MAX));
  assign bad_d       = win_good ? '0 : bad_cnt + BW'(1);
  assign bad_fail    = !win_good && (bad_cnt == BW'(FAIL_LIMIT - 1));
  assign restart     = io.FORCE_RESEQ || (state_nxt != state);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_SETTLE;
      dom_rst    <= '1;
      ready      <= 1'b0;
      osc_fault  <= 1'b0;
      last_count <= '0;
    end else begin
      state      <= state_nxt;
      dom_rst    <= dom_rst_d;
      ready      <= ready_d;
      osc_fault  <= osc_fault_d;
      last_count <= last_count_d;
    end
  end

  always_comb begin
    state_nxt = state;
    if (io.FORCE_RESEQ) begin
      state_nxt = S_SETTLE;
    end else begin
      case (state)
        S_SETTLE:    if (settle_done) state_nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: if (lock_ok) state_nxt = (NUM_DOMAINS == 1) ? S_RUN : S_RELEASE;
        S_RELEASE: begin
          if (!lock_s2)                   state_nxt = S_WAIT_LOCK;
          else if (stag_done && last_rel) state_nxt = S_RUN;
        end
        S_RUN: begin
          if (!lock_s2)                 state_nxt = S_WAIT_LOCK;
          else if (win_end && bad_fail) state_nxt = S_FAULT;
        end
        S_FAULT:     state_nxt = S_FAULT;
        default:     state_nxt = S_SETTLE;
      endcase
    end
  end

  // Outputs are computed from the next state so they register alongside it.
  always_comb begin
    dom_rst_d    = '1;
    ready_d      = 1'b0;
    osc_fault_d  = (state_nxt == S_FAULT);
    last_count_d = last_count;
    case (state_nxt)
      S_RELEASE: begin
        if (state != S_RELEASE) begin
          dom_rst_d[0] = 1'b0;
        end else begin
          dom_rst_d = dom_rst;
          if (stag_done) begin
            for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
              if (4'(i) == rel_idx) dom_rst_d[i] = 1'b0;
            end
          end
        end
      end
      S_RUN: begin
        dom_rst_d = '0;
        ready_d   = 1'b1;
      end
      default: ;
    endcase
    if (state == S_RUN && win_end && !io.FORCE_RESEQ) last_count_d = win_count;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
      tick_s1 <= 1'b0;
      tick_s2 <= 1'b0;
      tick_s3 <= 1'b0;
    end else begin
      lock_s1 <= io.PLL_LOCK;
      lock_s2 <= lock_s1;
      tick_s1 <= io.TICK_1MHZ;
      tick_s2 <= tick_s1;
      tick_s3 <= tick_s2;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || restart) begin
      settle_cnt <= '0;
      lock_cnt   <= '0;
      stag_cnt   <= '0;
      rel_idx    <= 4'd1;
      win_cnt    <= '0;
      tick_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      case (state)
        S_SETTLE:    settle_cnt <= settle_cnt + SW'(1);
        S_WAIT_LOCK: lock_cnt <= !lock_s2 ? '0 : (lock_ok ? lock_cnt : lock_cnt + LW'(1));
        S_RELEASE: begin
          if (stag_done) begin
            stag_cnt <= '0;
            rel_idx  <= rel_idx + 4'd1;
          end else begin
            stag_cnt <= stag_cnt + GW'(1);
          end
        end
        S_RUN: begin
          if (win_end) begin
            win_cnt  <= '0;
            tick_cnt <= '0;
            bad_cnt  <= bad_d;
          end else begin
            win_cnt  <= win_cnt + WW'(1);
            tick_cnt <= win_count;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.DOMAIN_RST = dom_rst;
  assign io.READY      = ready;
  assign io.OSC_FAULT  = osc_fault;
  assign io.STATE      = state;
  assign io.LAST_COUNT = last_count;

endmodule

// File: tb/tb_osc_reset_sequencer.sv
// Directed bench for osc_reset_sequencer: release timing, lock loss/glitch,
// tick supervision faults, forced resequence and tick-count saturation.
module tb_osc_reset_sequencer;

  logic CLK = 1'b0;
  logic RESET, RESET2;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned tick_mode = 1;  // 0 low, 1 1MHz, 2 5MHz
  logic sat_en = 1'b0;

  always #10 CLK = ~CLK;

  osc_reset_sequencer_if #(.NUM_DOMAINS(3)) bus ();
  osc_reset_sequencer_if #(.NUM_DOMAINS(3)) bus2 ();

  osc_reset_sequencer #(
    .NUM_DOMAINS(3), .SETTLE_CYCLES(16), .LOCK_FILTER(4), .STAGGER_CYCLES(8),
    .WINDOW_CYCLES(100), .TICK_MIN(1), .TICK_MAX(3), .FAIL_LIMIT(2)
  ) u_dut (.CLK(CLK), .RESET(RESET), .io(bus.master));

  osc_reset_sequencer #(
    .NUM_DOMAINS(3), .SETTLE_CYCLES(16), .LOCK_FILTER(4), .STAGGER_CYCLES(8),
    .WINDOW_CYCLES(1000), .TICK_MIN(1), .TICK_MAX(3), .FAIL_LIMIT(2)
  ) u_dut_sat (.CLK(CLK), .RESET(RESET2), .io(bus2.master));

  // Tick pin changes 2 ns after the active edge; phase restarts on every mode change.
  initial begin
    int unsigned ph = 0;
    int unsigned prev = 99;
    bus.TICK_1MHZ  = 1'b0;
    bus2.TICK_1MHZ = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      if (tick_mode != prev) ph = 0;
      prev = tick_mode;
      case (tick_mode)
        1: begin bus.TICK_1MHZ = (ph < 25); ph = (ph + 1) % 50; end
        2: begin bus.TICK_1MHZ = (ph < 5);  ph = (ph + 1) % 10; end
        default: bus.TICK_1MHZ = 1'b0;
      endcase
      if (sat_en) bus2.TICK_1MHZ = ~bus2.TICK_1MHZ;
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  initial begin
    RESET = 1'b1;
    RESET2 = 1'b1;
    bus.PLL_LOCK = 1'b0;
    bus.FORCE_RESEQ = 1'b0;
    bus2.PLL_LOCK = 1'b1;
    bus2.FORCE_RESEQ = 1'b0;

    step(3);
    check("rst_state", bus.STATE, 0);
    check("rst_dom", bus.DOMAIN_RST, 3'b111);
    check("rst_ready", bus.READY, 0);
    check("rst_fault", bus.OSC_FAULT, 0);
    check("rst_last", bus.LAST_COUNT, 0);
    RESET = 1'b0;

    // Release timing: lock pin rises as WAIT_LOCK is entered.
    step(15); check("settle_c15", bus.STATE, 0);
    step(1);  check("wait_c16", bus.STATE, 1);
    bus.PLL_LOCK = 1'b1;
    step(6);  check("wait_c22", bus.STATE, 1);
    check("dom_c22", bus.DOMAIN_RST, 3'b111);
    step(1);  check("rel_c23", bus.STATE, 2);
    check("dom_c23", bus.DOMAIN_RST, 3'b110);
    step(7);  check("dom_c30", bus.DOMAIN_RST, 3'b110);
    step(1);  check("dom_c31", bus.DOMAIN_RST, 3'b100);
    step(7);  check("dom_c38", bus.DOMAIN_RST, 3'b100);
    check("ready_c38", bus.READY, 0);
    step(1);  check("dom_c39", bus.DOMAIN_RST, 3'b000);
    check("ready_c39", bus.READY, 1);
    check("run_c39", bus.STATE, 3);
    step(99); check("last_c138", bus.LAST_COUNT, 0);
    step(1);  check("last_c139", bus.LAST_COUNT, 2);

    // One-cycle lock loss in RUN.
    step(11); bus.PLL_LOCK = 1'b0;
    step(1);  bus.PLL_LOCK = 1'b1;
    step(1);  check("loss_run", bus.STATE, 3);
    check("loss_ready_pre", bus.READY, 1);
    step(1);  check("loss_state", bus.STATE, 1);
    check("loss_dom", bus.DOMAIN_RST, 3'b111);
    check("loss_ready", bus.READY, 0);
    check("loss_last_hold", bus.LAST_COUNT, 2);
    step(4);  check("relock_wait", bus.STATE, 1);
    step(1);  check("relock_rel", bus.STATE, 2);
    check("relock_dom", bus.DOMAIN_RST, 3'b110);
    step(16); check("relock_run", bus.STATE, 3);
    check("relock_ready", bus.READY, 1);

    // Forced resequence, then a lock glitch during WAIT_LOCK.
    step(6);
    bus.FORCE_RESEQ = 1'b1;
    bus.PLL_LOCK = 1'b0;
    step(1);  bus.FORCE_RESEQ = 1'b0;
    check("force_state", bus.STATE, 0);
    check("force_dom", bus.DOMAIN_RST, 3'b111);
    check("force_ready", bus.READY, 0);
    check("force_last", bus.LAST_COUNT, 2);
    step(16); check("glitch_wait", bus.STATE, 1);
    bus.PLL_LOCK = 1'b1;
    step(3);  bus.PLL_LOCK = 1'b0;
    step(1);  bus.PLL_LOCK = 1'b1;
    step(3);  check("glitch_w7", bus.STATE, 1);
    step(3);  check("glitch_w10", bus.STATE, 1);
    step(1);  check("glitch_rel", bus.STATE, 2);
    tick_mode = 0;

    // Stopped tick: two bad windows fault.
    step(16); check("stop_run", bus.STATE, 3);
    step(100); check("stop_last1", bus.LAST_COUNT, 0);
    check("stop_run1", bus.STATE, 3);
    step(99); check("stop_pre", bus.STATE, 3);
    step(1);  check("stop_fault", bus.STATE, 4);
    check("stop_osc_fault", bus.OSC_FAULT, 1);
    check("stop_dom", bus.DOMAIN_RST, 3'b111);
    check("stop_ready", bus.READY, 0);
    step(20); check("fault_sticky", bus.STATE, 4);

    // Recovery by FORCE_RESEQ; one bad window followed by good ones.
    bus.FORCE_RESEQ = 1'b1;
    tick_mode = 1;
    step(1);  bus.FORCE_RESEQ = 1'b0;
    check("rec_state", bus.STATE, 0);
    check("rec_fault", bus.OSC_FAULT, 0);
    check("rec_last", bus.LAST_COUNT, 0);
    step(16); check("rec_wait", bus.STATE, 1);
    step(5);  check("rec_rel", bus.STATE, 2);
    check("rec_dom", bus.DOMAIN_RST, 3'b110);
    tick_mode = 0;
    step(16); check("rec_run", bus.STATE, 3);
    step(100); check("bad1_last", bus.LAST_COUNT, 0);
    check("bad1_state", bus.STATE, 3);
    tick_mode = 1;
    step(100); check("good_last", bus.LAST_COUNT, 2);
    check("good_state", bus.STATE, 3);
    step(100); check("good2_last", bus.LAST_COUNT, 2);
    check("good2_state", bus.STATE, 3);

    // Overspeed: 10 ticks per window.
    tick_mode = 2;
    step(100); check("fast_last", bus.LAST_COUNT, 10);
    check("fast_state", bus.STATE, 3);
    step(100); check("fast_fault", bus.STATE, 4);
    check("fast_osc_fault", bus.OSC_FAULT, 1);
    check("fast_last2", bus.LAST_COUNT, 10);

    // RESET wins over a simultaneous FORCE_RESEQ.
    RESET = 1'b1;
    bus.FORCE_RESEQ = 1'b1;
    step(1);
    check("rf_state", bus.STATE, 0);
    check("rf_fault", bus.OSC_FAULT, 0);
    check("rf_last", bus.LAST_COUNT, 0);
    check("rf_dom", bus.DOMAIN_RST, 3'b111);
    check("rf_ready", bus.READY, 0);
    RESET = 1'b0;
    bus.FORCE_RESEQ = 1'b0;

    // Saturation: toggling tick gives 500 edges in a 1000-cycle window.
    sat_en = 1'b1;
    RESET2 = 1'b0;
    step(1036); check("sat_pre", bus2.LAST_COUNT, 0);
    step(1);    check("sat_last", bus2.LAST_COUNT, 255);
    check("sat_state", bus2.STATE, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
